// File: rtl/core_pkg.sv
// Definitions shared across the RV32I pipeline stages: datapath widths and the
// writeback-select encodings.
package core_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned REG_IDX_W = 5;

    typedef enum logic [1:0] {
        RESULT_ALU = 2'b00,
        RESULT_MEM = 2'b01,
        RESULT_PC4 = 2'b10
    } result_src_e;

endpackage

// File: rtl/memory_cycle_if.sv
// M-stage inputs and W-stage outputs of the memory stage, bundled as one interface.
// The stage itself connects through the slave modport.
interface memory_cycle_if;
    import core_pkg::*;

    logic                 RegWriteM;
    logic                 MemWriteM;
    logic [1:0]           ResultSrcM;
    logic [REG_IDX_W-1:0] RD_M;
    logic [XLEN-1:0]      PCPlus4M;
    logic [XLEN-1:0]      WriteDataM;
    logic [XLEN-1:0]      ALU_ResultM;

    logic                 RegWriteW;
    logic [1:0]           ResultSrcW;
    logic [REG_IDX_W-1:0] RD_W;
    logic [XLEN-1:0]      PCPlus4W;
    logic [XLEN-1:0]      ALU_ResultW;
    logic [XLEN-1:0]      ReadDataW;

    modport master (
        output RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM,
        input  RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW
    );

    modport slave (
        input  RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM,
        output RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW
    );

endinterface

// File: rtl/data_memory.sv
// Word-addressed data memory: synchronous write, asynchronous read. Contents are
// never reset; byte-address bits outside [ADDR_W+1:2] are ignored so addresses wrap.
module data_memory
    import core_pkg::*;
#(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            WE,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] WD,
    output logic [XLEN-1:0] RD
);

    logic [XLEN-1:0]   r_mem [DEPTH];
    logic [ADDR_W-1:0] w_index;
    logic              w_unused_addr;

    assign w_index       = A[ADDR_W+1:2];
    assign w_unused_addr = ^{A[XLEN-1:ADDR_W+2], A[1:0]};

    // Stores are suppressed while reset is held low.
    always_ff @(posedge clk) begin
        if (rst && WE) begin
            r_mem[w_index] <= WD;
        end
    end

    assign RD = r_mem[w_index];

endmodule

// File: rtl/memory_cycle.sv
// Memory stage of the 5-stage RV32I core: performs the data-memory access and
// registers the M/W bundle for writeback.
module memory_cycle
    import core_pkg::*;
#(
    parameter int unsigned DMEM_DEPTH = 1024,
    parameter int unsigned ADDR_W     = 10
) (
    input  logic          clk,
    input  logic          rst,
    memory_cycle_if.slave bus
);

    logic [XLEN-1:0]      w_read_data;

    logic                 r_reg_write;
    logic [1:0]           r_result_src;
    logic [REG_IDX_W-1:0] r_rd;
    logic [XLEN-1:0]      r_pc_plus4;
    logic [XLEN-1:0]      r_alu_result;
    logic [XLEN-1:0]      r_read_data;

    data_memory #(
        .DEPTH  (DMEM_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_dmem (
        .clk (clk),
        .rst (rst),
        .WE  (bus.MemWriteM),
        .A   (bus.ALU_ResultM),
        .WD  (bus.WriteDataM),
        .RD  (w_read_data)
    );

    // The read port sees pre-store contents, so a same-edge store/load returns old data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_reg_write  <= 1'b0;
            r_result_src <= RESULT_ALU;
            r_rd         <= '0;
            r_pc_plus4   <= '0;
            r_alu_result <= '0;
            r_read_data  <= '0;
        end else begin
            r_reg_write  <= bus.RegWriteM;
            r_result_src <= bus.ResultSrcM;
            r_rd         <= bus.RD_M;
            r_pc_plus4   <= bus.PCPlus4M;
            r_alu_result <= bus.ALU_ResultM;
            r_read_data  <= w_read_data;
        end
    end

    assign bus.RegWriteW   = r_reg_write;
    assign bus.ResultSrcW  = r_result_src;
    assign bus.RD_W        = r_rd;
    assign bus.PCPlus4W    = r_pc_plus4;
    assign bus.ALU_ResultW = r_alu_result;
    assign bus.ReadDataW   = r_read_data;

endmodule

// File: tb/tb_memory_cycle.sv
// Directed bench for memory_cycle: reset behaviour, pass-through, store/load,
// read-before-write, address alignment/wrap and asynchronous reset.
module tb_memory_cycle;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    memory_cycle_if bus ();

    memory_cycle #(
        .DMEM_DEPTH (1024),
        .ADDR_W     (10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_regwrite"}, {31'd0, bus.RegWriteW}, 32'd0);
        check({tag, "_resultsrc"}, {30'd0, bus.ResultSrcW}, 32'd0);
        check({tag, "_rd"}, {27'd0, bus.RD_W}, 32'd0);
        check({tag, "_pc4"}, bus.PCPlus4W, 32'd0);
        check({tag, "_alu"}, bus.ALU_ResultW, 32'd0);
        check({tag, "_rdata"}, bus.ReadDataW, 32'd0);
    endtask

    task automatic drive(input logic rw, input logic mw, input logic [1:0] rs,
                         input logic [4:0] rd, input logic [31:0] pc4,
                         input logic [31:0] wd, input logic [31:0] alu);
        bus.RegWriteM   = rw;
        bus.MemWriteM   = mw;
        bus.ResultSrcM  = rs;
        bus.RD_M        = rd;
        bus.PCPlus4M    = pc4;
        bus.WriteDataM  = wd;
        bus.ALU_ResultM = alu;
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        // Reset held with toggling inputs.
        rst = 1'b0;
        drive(1'b1, 1'b1, 2'b10, 5'd9, 32'h1234, 32'hDEAD, 32'h10);
        tick();
        drive(1'b1, 1'b0, 2'b01, 5'd31, 32'hFFFF_FFFF, 32'h5A5A, 32'hFFFF_FFF0);
        tick();
        check_all_zero("reset_hold");

        // Release between edges; first edge samples pass-through inputs.
        rst = 1'b1;
        drive(1'b1, 1'b0, 2'b00, 5'd5, 32'h59, 32'h0, 32'hAD);
        tick();
        check("pass_regwrite", {31'd0, bus.RegWriteW}, 32'd1);
        check("pass_resultsrc", {30'd0, bus.ResultSrcW}, 32'd0);
        check("pass_rd", {27'd0, bus.RD_W}, 32'd5);
        check("pass_pc4", bus.PCPlus4W, 32'h59);
        check("pass_alu", bus.ALU_ResultW, 32'hAD);

        // Seed 0x10 so the reset-blocked store can be detected later.
        drive(1'b0, 1'b1, 2'b00, 5'd0, 32'h0, 32'h1111, 32'h10);
        tick();

        // Store then load.
        drive(1'b0, 1'b1, 2'b00, 5'd0, 32'h0, 32'h1234_5678, 32'h20);
        tick();
        drive(1'b1, 1'b0, 2'b01, 5'd12, 32'h64, 32'h0, 32'h20);
        tick();
        check("stld_rdata", bus.ReadDataW, 32'h1234_5678);
        check("stld_resultsrc", {30'd0, bus.ResultSrcW}, 32'd1);
        check("stld_rd", {27'd0, bus.RD_W}, 32'd12);

        // Async reset mid-operation: outputs clear before the next edge.
        check("pre_async_regwrite", {31'd0, bus.RegWriteW}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("async_reset");

        // Store presented during reset must be blocked.
        drive(1'b1, 1'b1, 2'b01, 5'd3, 32'h8, 32'hDEAD, 32'h10);
        tick();
        check_all_zero("reset_store");
        rst = 1'b1;
        drive(1'b1, 1'b0, 2'b01, 5'd3, 32'h8, 32'h0, 32'h10);
        tick();
        check("no_store_in_reset", bus.ReadDataW, 32'h1111);

        // Store on the first edge after reset release takes effect.
        rst = 1'b0;
        #2;
        rst = 1'b1;
        drive(1'b0, 1'b1, 2'b00, 5'd0, 32'h0, 32'h77, 32'h30);
        tick();
        drive(1'b0, 1'b0, 2'b01, 5'd0, 32'h0, 32'h0, 32'h30);
        tick();
        check("store_after_release", bus.ReadDataW, 32'h77);

        // Read-before-write on the same index.
        drive(1'b0, 1'b1, 2'b00, 5'd0, 32'h0, 32'hAAAA, 32'h8);
        tick();
        drive(1'b0, 1'b1, 2'b00, 5'd0, 32'h0, 32'hBBBB, 32'h8);
        tick();
        check("rbw_old", bus.ReadDataW, 32'hAAAA);
        drive(1'b0, 1'b0, 2'b01, 5'd0, 32'h0, 32'h0, 32'h8);
        tick();
        check("rbw_new", bus.ReadDataW, 32'hBBBB);

        // Alignment and wrap.
        drive(1'b0, 1'b1, 2'b00, 5'd0, 32'h0, 32'hCAFE, 32'h4);
        tick();
        drive(1'b0, 1'b0, 2'b01, 5'd0, 32'h0, 32'h0, 32'h7);
        tick();
        check("align_low_bits", bus.ReadDataW, 32'hCAFE);
        drive(1'b0, 1'b0, 2'b01, 5'd0, 32'h0, 32'h0, 32'h1004);
        tick();
        check("wrap_load", bus.ReadDataW, 32'hCAFE);
        check("wrap_alu_passthru", bus.ALU_ResultW, 32'h1004);
        drive(1'b0, 1'b1, 2'b00, 5'd0, 32'h0, 32'h5555, 32'h8000_1008);
        tick();
        drive(1'b0, 1'b0, 2'b01, 5'd0, 32'h0, 32'h0, 32'h8);
        tick();
        check("wrap_store", bus.ReadDataW, 32'h5555);
        drive(1'b0, 1'b0, 2'b01, 5'd0, 32'h0, 32'h0, 32'h20);
        tick();
        check("untouched_word", bus.ReadDataW, 32'h1234_5678);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/memory_cycle.md
Name: memory_cycle

Overview:
Pipeline stage directly downstream of execute_cycle in the 5-stage RV32I core. It consumes the M-stage bundle that execute_cycle registers (ALU_ResultM, WriteDataM, control, RD_M, PCPlus4M). It performs the data-memory load or store, then registers the M/W pipeline bundle for the writeback stage. It owns the data memory as an instantiated sub-module.

Parameters:
DMEM_DEPTH, 1024, number of 32-bit words in data memory (power of two)
ADDR_W, 10, word-index width; must equal log2(DMEM_DEPTH)

Ports:
clk  input  1  core clock, rising-edge active
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
RegWriteM  input  1  register-file write enable from E/M register
MemWriteM  input  1  data-memory store enable
ResultSrcM  input  2  writeback select (00 ALU, 01 load data, 10 PC+4)
RD_M  input  5  destination register index
PCPlus4M  input  32  PC+4 of the instruction
WriteDataM  input  32  store data (rs2 value)
ALU_ResultM  input  32  effective address, or ALU result
RegWriteW  output  1  registered RegWriteM
ResultSrcW  output  2  registered ResultSrcM
RD_W  output  5  registered RD_M
PCPlus4W  output  32  registered PCPlus4M
ALU_ResultW  output  32  registered ALU_ResultM
ReadDataW  output  32  registered load data

Behaviour:
- Reset (rst=0, asynchronous): all W outputs clear to 0. RegWriteW=0 guarantees no register-file write during or just after reset. Data-memory contents are NOT reset. Stores are blocked while rst=0.
- Latency: exactly 1 cycle. Inputs present before edge N appear on the *W outputs after edge N. No stall or flush inputs; the stage updates every cycle.
- Address: word index = ALU_ResultM[ADDR_W+1:2]. Bits [1:0] are ignored (word access only). Upper bits above ADDR_W+1 are ignored, so addresses wrap modulo 4*DMEM_DEPTH bytes.
- Read: combinational array read at the word index, captured into ReadDataW at the edge. The read happens every cycle regardless of ResultSrcM; ReadDataW is only meaningful when ResultSrcW=01.
- Write: at the rising edge, when rst=1 and MemWriteM=1, mem[index] <= WriteDataM (full 32 bits).
- Same-cycle store and read to the same index: ReadDataW returns the OLD contents (read-before-write). The new value is visible from the next cycle.
- Back-to-back store then load to the same address: the load captures the stored value.
- Reset deasserted mid-stream: the first edge after rst rises samples inputs normally. Any store presented on that edge takes effect.
- Control is passed through unchanged. The block does not qualify RegWriteM with the load.
- Out-of-range addresses are never an error; they wrap.

Decomposition:
- Shared package core_pkg: ResultSrc encodings RESULT_ALU=2'b00, RESULT_MEM=2'b01, RESULT_PC4=2'b10; XLEN=32; REG_IDX_W=5.
- Sub-module data_memory (params DEPTH, ADDR_W): ports clk, rst, WE, A[31:0], WD[31:0], RD[31:0]. It has a synchronous write and an asynchronous read. memory_cycle instantiates it and holds only the M/W pipeline register.

Test Plan:
- Reset: rst=0 with arbitrary inputs toggling -> all W outputs 0. Apply MemWriteM=1, ALU_ResultM=0x10, WriteDataM=0xDEAD; then release reset and read 0x10 -> contents unchanged (no store during reset).
- Pass-through: RegWriteM=1, ResultSrcM=00, RD_M=5, PCPlus4M=0x59, ALU_ResultM=0xAD, MemWriteM=0 -> next edge gives RegWriteW=1, ResultSrcW=00, RD_W=5, PCPlus4W=0x59, ALU_ResultW=0xAD.
- Store then load: cycle 1 MemWriteM=1, ALU_ResultM=0x20, WriteDataM=0x12345678; cycle 2 MemWriteM=0, ResultSrcM=01, ALU_ResultM=0x20 -> ReadDataW=0x12345678 after edge 2.
- Read-before-write: mem[0x8] holds 0xAAAA; one cycle with MemWriteM=1, ALU_ResultM=0x8, WriteDataM=0xBBBB -> ReadDataW=0xAAAA that edge; a load next cycle returns 0xBBBB.
- Alignment and wrap: store 0xCAFE at 0x4; load from 0x7 -> 0xCAFE. Load from 0x4 + 4*DMEM_DEPTH (0x1004 at default) -> 0xCAFE.
- Async reset mid-operation: assert rst=0 between edges while RegWriteW=1 -> RegWriteW and all W outputs drop to 0 immediately, without waiting for a clock edge.
